sha512_stream: RTL and testbench

- Streaming SHA-512 compression engine for messages of any number of pre-padded 1024-bit blocks.
- Successor to the fixed two-chunk core:
  - valid/ready handshakes on block input and digest output;
  - first/last block framing;
  - parametrised rounds per cycle;
  - optional SHA-384 mode.
- Sits between the padding/packer stage and digest consumers such as the hash comparator.
- Padding is not performed here.

---
 rtl/sha512_pkg.sv | 80 ++++++++
 rtl/sha512_stream_if.sv | 25 ++
 rtl/sha512_round.sv | 21 ++
 rtl/sha512_stream.sv | 155 +++++++++++++++
 tb/tb_sha512_stream.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sha512_pkg.sv
// Shared constants, helper functions and types for the streaming SHA-512 engine.
// Round constants, both initial hash values, the sigma/choice/majority helpers and the FSM state type.
package sha512_pkg;

  typedef logic [63:0] word_t;

  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } wv_t;

  typedef enum logic [1:0] {IDLE, COMPRESS, FINAL, HOLD} state_e;

  localparam wv_t IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam wv_t IV384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};

  localparam word_t K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  function automatic word_t rotr64(input word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic wv_t add_wv(input wv_t x, input wv_t y);
    return '{a: x.a + y.a, b: x.b + y.b, c: x.c + y.c, d: x.d + y.d,
             e: x.e + y.e, f: x.f + y.f, g: x.g + y.g, h: x.h + y.h};
  endfunction

  function automatic wv_t iv_of(input logic m384);
    return m384 ? IV384 : IV512;
  endfunction

endpackage

// File: rtl/sha512_stream_if.sv
// Block-in / digest-out handshake bundle for sha512_stream.
// SHA512_384_MODE_EN adds the mode384 select, driven alongside in_first.
interface sha512_stream_if;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] in_block;
  logic          in_first;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [511:0]  out_digest;
`ifdef SHA512_384_MODE_EN
  logic          mode384;

  modport master (output in_valid, in_block, in_first, in_last, out_ready, mode384,
                  input  in_ready, out_valid, out_digest);
  modport slave  (input  in_valid, in_block, in_first, in_last, out_ready, mode384,
                  output in_ready, out_valid, out_digest);
`else
  modport master (output in_valid, in_block, in_first, in_last, out_ready,
                  input  in_ready, out_valid, out_digest);
  modport slave  (input  in_valid, in_block, in_first, in_last, out_ready,
                  output in_ready, out_valid, out_digest);
`endif
endinterface

// File: rtl/sha512_round.sv
// One combinational SHA-512 round: working variables, round constant and schedule word in,
// updated working variables out.
module sha512_round
  import sha512_pkg::*;
(
  input  wv_t   st_i,
  input  word_t k_i,
  input  word_t w_i,
  output wv_t   st_o
);

  word_t t1, t2;

  always_comb begin
    t1   = st_i.h + big_sigma1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
    t2   = big_sigma0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);
    st_o = '{a: t1 + t2, b: st_i.a, c: st_i.b, d: st_i.c,
             e: st_i.d + t1, f: st_i.e, g: st_i.f, h: st_i.g};
  end

endmodule

// File: rtl/sha512_stream.sv
// Streaming SHA-512 compression engine over pre-padded 1024-bit blocks, UNROLL rounds per cycle.
// Define SHA512_384_MODE_EN to add the mode384 port and SHA-384 output truncation.
module sha512_stream
  import sha512_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic            clk,
  input logic            reset,
  sha512_stream_if.slave bus
);

  localparam int         NROUND_CYC = 80 / UNROLL;
  localparam logic [6:0] LAST_CYC   = 7'(NROUND_CYC - 1);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5 ||
        UNROLL == 8 || UNROLL == 10 || UNROLL == 16)) begin : g_bad_unroll
    $error("sha512_stream: UNROLL must divide 80 and be at most 16");
  end

  state_e             state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic [511:0]       digest_q, digest_d;
  wv_t                h_q, h_d, wv_q, wv_d, hsum;
  logic [15:0][63:0]  w_q, w_d;
  word_t              ext [16+UNROLL];
  wv_t                chain [UNROLL+1];
  logic               in_ready, accept, mode_in, mode_q;

`ifdef SHA512_384_MODE_EN
  logic mode_d;
  assign mode_in = bus.mode384;
  always_ff @(posedge clk) begin
    if (reset) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`else
  assign mode_in = 1'b0;
  assign mode_q  = 1'b0;
`endif

  assign in_ready       = (state_q == IDLE) && !reset;
  assign accept         = bus.in_valid && in_ready;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_digest = digest_q;
  assign hsum           = add_wv(h_q, wv_q);

  // Schedule window plus the UNROLL words that slide in next; w_q[15] holds W[t].
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[15-i];
    for (int k = 0; k < UNROLL; k++)
      ext[16+k] = small_sigma1(ext[14+k]) + ext[9+k] + small_sigma0(ext[1+k]) + ext[k];
  end

  assign chain[0] = wv_q;
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [6:0] kidx;
    assign kidx = 7'(int'(cnt_q) * UNROLL + j);
    sha512_round u_round (
      .st_i (chain[j]),
      .k_i  (K[kidx]),
      .w_i  (ext[j]),
      .st_o (chain[j+1])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    digest_d    = digest_q;
    h_d         = h_q;
    wv_d        = wv_q;
    w_d         = w_q;
`ifdef SHA512_384_MODE_EN
    mode_d      = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          w_d    = bus.in_block;
          last_d = bus.in_last;
          cnt_d  = '0;
          if (bus.in_first) begin
            h_d  = iv_of(mode_in);
            wv_d = iv_of(mode_in);
`ifdef SHA512_384_MODE_EN
            mode_d = mode_in;
`endif
          end else begin
            wv_d = h_q;
          end
          state_d = COMPRESS;
        end
      end
      COMPRESS: begin
        wv_d = chain[UNROLL];
        for (int i = 0; i < 16; i++) w_d[15-i] = ext[i+UNROLL];
        if (cnt_q == LAST_CYC) begin
          cnt_d   = '0;
          state_d = FINAL;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      FINAL: begin
        // H goes back to the IV after a last block so an unflagged follow-on block starts clean.
        if (last_q) begin
          digest_d    = mode_q ? {hsum[511:128], 128'b0} : hsum;
          out_valid_d = 1'b1;
          h_d         = iv_of(mode_q);
          state_d     = HOLD;
        end else begin
          h_d     = hsum;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
      h_q         <= IV512;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      digest_q    <= digest_d;
      h_q         <= h_d;
    end
  end

  always_ff @(posedge clk) begin
    wv_q <= wv_d;
    w_q  <= w_d;
  end

endmodule

// File: tb/tb_sha512_stream.sv
// Directed bench for sha512_stream: known-answer digests, latency, backpressure, reset recovery.
// The SHA-384 vector is exercised when SHA512_384_MODE_EN is defined.
module tb_sha512_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha512_stream_if bus1();
  sha512_stream_if bus8();

  sha512_stream #(.UNROLL(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  sha512_stream #(.UNROLL(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  localparam logic [511:0] DIG_ABC = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [511:0] DIG_EMPTY = 512'hcf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e;
  localparam logic [511:0] DIG_TWO = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;
  localparam logic [511:0] DIG_384_ABC = {384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, 128'h0};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1023:0] blk_abc();
    logic [1023:0] b = '0;
    b[1023:992] = 32'h61626380;
    b[7:0]      = 8'h18;
    return b;
  endfunction

  function automatic logic [1023:0] blk_empty();
    logic [1023:0] b = '0;
    b[1023] = 1'b1;
    return b;
  endfunction

  function automatic logic [1023:0] blk_two1();
    logic [1023:0] b = '0;
    for (int n = 0; n < 112; n++) b[1023-8*n -: 8] = 8'(8'h61 + n / 8 + n % 8);
    b[127:120] = 8'h80;
    return b;
  endfunction

  function automatic logic [1023:0] blk_two2();
    logic [1023:0] b = '0;
    b[15:0] = 16'h0380;
    return b;
  endfunction

  task automatic send_block(input logic [1023:0] b, input logic f, input logic l);
    int g = 0;
    while (!bus1.in_ready && g < 300) begin
      @(posedge clk); #1; g++;
    end
    check_val("in_ready_before_send", 512'(bus1.in_ready), 512'd1);
    bus1.in_block = b;
    bus1.in_first = f;
    bus1.in_last  = l;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_digest(output int lat);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1; lat++;
      if (bus1.out_valid) break;
    end
  endtask

  task automatic consume();
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    bus1.in_valid = 1'b0; bus1.in_block = '0; bus1.in_first = 1'b0; bus1.in_last = 1'b0; bus1.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_block = '0; bus8.in_first = 1'b0; bus8.in_last = 1'b0; bus8.out_ready = 1'b0;
`ifdef SHA512_384_MODE_EN
    bus1.mode384 = 1'b0;
    bus8.mode384 = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 512'(bus1.in_ready), 512'd0);
    check_val("rst_out_valid", 512'(bus1.out_valid), 512'd0);
    check_val("rst_digest", bus1.out_digest, 512'd0);
    check_val("rst_in_ready_u8", 512'(bus8.in_ready), 512'd0);
    reset = 1'b0;
    #1;
    check_val("post_rst_in_ready", 512'(bus1.in_ready), 512'd1);

    // "abc", UNROLL=1
    send_block(blk_abc(), 1'b1, 1'b1);
    check_val("busy_in_ready", 512'(bus1.in_ready), 512'd0);
    wait_digest(lat);
    check_val("abc_latency", 512'(lat), 512'd81);
    check_val("abc_digest", bus1.out_digest, DIG_ABC);
    consume();
    check_val("abc_out_valid_drop", 512'(bus1.out_valid), 512'd0);
    check_val("abc_digest_kept", bus1.out_digest, DIG_ABC);

    // empty message, UNROLL=8
    bus8.in_block = blk_empty(); bus8.in_first = 1'b1; bus8.in_last = 1'b1; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1; lat++;
      if (bus8.out_valid) break;
    end
    check_val("empty_u8_latency", 512'(lat), 512'd11);
    check_val("empty_u8_digest", bus8.out_digest, DIG_EMPTY);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check_val("empty_u8_out_valid_drop", 512'(bus8.out_valid), 512'd0);

    // two-block message with a 3-cycle gap
    send_block(blk_two1(), 1'b1, 1'b0);
    seen = 0; lat = 0;
    while (!bus1.in_ready && lat < 300) begin
      @(posedge clk); #1; lat++;
      if (bus1.out_valid) seen++;
    end
    check_val("two_no_mid_digest", 512'(seen), 512'd0);
    repeat (3) @(posedge clk);
    #1;
    send_block(blk_two2(), 1'b0, 1'b1);
    wait_digest(lat);
    check_val("two_digest", bus1.out_digest, DIG_TWO);
    consume();

    // backpressure: 20 cycles of out_ready low
    send_block(blk_abc(), 1'b1, 1'b1);
    wait_digest(lat);
    for (int c = 0; c < 20; c++) begin
      check_val("bp_out_valid", 512'(bus1.out_valid), 512'd1);
      check_val("bp_digest", bus1.out_digest, DIG_ABC);
      check_val("bp_in_ready", 512'(bus1.in_ready), 512'd0);
      @(posedge clk); #1;
    end
    consume();
    check_val("bp_released", 512'(bus1.out_valid), 512'd0);

    // follow-on block without in_first starts from the IV
    send_block(blk_abc(), 1'b0, 1'b1);
    wait_digest(lat);
    check_val("iv_reload_digest", bus1.out_digest, DIG_ABC);
    consume();

    // reset partway through compression
    send_block(blk_two1(), 1'b1, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_in_ready", 512'(bus1.in_ready), 512'd0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (bus1.out_valid) seen++;
    end
    check_val("mid_rst_no_digest", 512'(seen), 512'd0);
    check_val("mid_rst_digest_cleared", bus1.out_digest, 512'd0);
    send_block(blk_abc(), 1'b1, 1'b1);
    wait_digest(lat);
    check_val("after_rst_abc", bus1.out_digest, DIG_ABC);
    consume();

`ifdef SHA512_384_MODE_EN
    bus1.mode384 = 1'b1;
    send_block(blk_abc(), 1'b1, 1'b1);
    bus1.mode384 = 1'b0;
    wait_digest(lat);
    check_val("sha384_abc", bus1.out_digest, DIG_384_ABC);
    consume();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
